// File: rtl/clk_div_meter.sv
// clk_div_meter: measures the high and low phase lengths of one div_clk period,
// counted in clk_in cycles, after a start request.
// Optional build macro DIV_METER_SYNC_EN inserts a 2-flop synchronizer ahead of
// the edge detector for a div_clk that is truly asynchronous to clk_in.
module clk_div_meter #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             div_clk,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period,
    output logic             duty50,
    output logic             timeout
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ARM, HIGH, LOW, DONE} state_t;

    state_t           state;
    logic             s;
    logic             prev;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] lcnt;
    logic [WD_W-1:0]  wdog;
    logic [CNT_W-1:0] diff;

`ifdef DIV_METER_SYNC_EN
    logic [1:0] sync;

    // Two-flop synchronizer, then the sampling flop that feeds the edge detector
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync <= 2'b00;
            s    <= 1'b0;
        end else begin
            sync <= {sync[0], div_clk};
            s    <= sync[1];
        end
    end
`else
    // Single sampling flop; only safe when div_clk is derived from clk_in
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) s <= 1'b0;
        else      s <= div_clk;
    end
`endif

    // Previous sample for edge detection
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) prev <= 1'b0;
        else      prev <= s;
    end

    wire rise     = s & ~prev;
    wire fall     = ~s & prev;
    wire edge_any = rise | fall;
    // Expiry only counts when no edge arrives in the same cycle; the edge wins
    wire wd_exp   = (wdog == WD_LAST) && !edge_any;

    // Absolute phase difference for the duty50 flag
    always_comb begin
        diff = '0;
        if (hcnt > lcnt) diff = hcnt - lcnt;
        else             diff = lcnt - hcnt;
    end

    // Measurement FSM with registered status and result outputs
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            high_cnt <= '0;
            low_cnt  <= '0;
            period   <= '0;
            duty50   <= 1'b0;
            timeout  <= 1'b0;
            hcnt     <= '0;
            lcnt     <= '0;
            wdog     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ARM;
                        busy    <= 1'b1;
                        timeout <= 1'b0;
                        wdog    <= '0;
                    end
                end
                ARM, HIGH, LOW: begin
                    if (edge_any) wdog <= '0;
                    else          wdog <= wdog + 1'b1;
                    if (wd_exp) begin
                        // Abort: results keep their previous values
                        state   <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else if (state == ARM) begin
                        // Wait for a genuine rise so a period is never
                        // measured from the middle of a high phase
                        if (rise) begin
                            state <= HIGH;
                            hcnt  <= CNT_W'(1);
                        end
                    end else if (state == HIGH) begin
                        if (fall) begin
                            state <= LOW;
                            lcnt  <= CNT_W'(1);
                        end else if (s && hcnt != CNT_MAX) begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end else begin
                        if (rise) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            high_cnt <= hcnt;
                            low_cnt  <= lcnt;
                            period   <= {1'b0, hcnt} + {1'b0, lcnt};
                            duty50   <= (diff <= CNT_W'(1));
                        end else if (!s && lcnt != CNT_MAX) begin
                            lcnt <= lcnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // done pulses during this state; start is ignored here
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_meter.sv
// Self-checking bench for clk_div_meter: directed and randomized div_clk
// patterns compared against a phase-length model.
module tb_clk_div_meter;

    localparam int CW = 6;
    localparam int TO = 255;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          div_clk;
    logic          start;
    logic          busy;
    logic          done;
    logic [CW-1:0] high_cnt;
    logic [CW-1:0] low_cnt;
    logic [CW:0]   period;
    logic          duty50;
    logic          timeout;

    int n_vec = 0;
    int n_err = 0;
    int ndone = 0;

    // Pattern generator: div_clk high for gh half-cycles, low for gl half-cycles
    int gh = 8;
    int gl = 8;
    bit gen_en = 1'b0;
    int gpos;

    clk_div_meter #(.CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .div_clk (div_clk),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .high_cnt(high_cnt),
        .low_cnt (low_cnt),
        .period  (period),
        .duty50  (duty50),
        .timeout (timeout)
    );

    always #5 clk_in = ~clk_in;

    task automatic gstep();
        if (gpos >= gh + gl) gpos = 0;
        div_clk = gen_en && (gpos < gh);
        gpos++;
    endtask

    initial begin
        gpos    = 0;
        div_clk = 1'b0;
        forever begin
            @(negedge clk_in); gstep();
            @(posedge clk_in); #1; gstep();
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            if (done) ndone++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic pat(input int hh, input int hl);
        gh     = hh;
        gl     = hl;
        gen_en = 1'b1;
        repeat (hh + hl + 8) @(negedge clk_in);
    endtask

    // One measurement; hh/hl are phase lengths in half clk_in cycles
    task automatic meas(input string tag, input int hh, input int hl, input bit spam);
        int mx, eh, el, ep, ed, k, nd0;
        mx  = (1 << CW) - 1;
        pat(hh, hl);
        nd0 = ndone;
        @(negedge clk_in); start = 1'b1;
        @(negedge clk_in); start = 1'b0;
        chk({tag, ":busy"}, busy, 1);
        k = 0;
        while (!done && k < 1500) begin
            @(negedge clk_in);
            k++;
            start = spam && (k % 5 == 0);
        end
        start = 1'b0;
        chk({tag, ":done"}, done, 1);
        if (hh % 2 == 0 && hl % 2 == 0) begin
            eh = (hh / 2 > mx) ? mx : hh / 2;
            el = (hl / 2 > mx) ? mx : hl / 2;
            ep = eh + el;
            ed = (eh - el <= 1 && el - eh <= 1) ? 1 : 0;
            chk({tag, ":high"}, high_cnt, eh);
            chk({tag, ":low"}, low_cnt, el);
            chk({tag, ":period"}, period, ep);
            chk({tag, ":duty50"}, duty50, ed);
        end else begin
            // Half-cycle edges: each phase rounds either way, the sum is exact
            chk({tag, ":period"}, period, (hh + hl) / 2);
            chk({tag, ":high_in"}, (high_cnt >= hh / 2 && high_cnt <= (hh + 1) / 2), 1);
            chk({tag, ":sum"}, high_cnt + low_cnt, (hh + hl) / 2);
            chk({tag, ":duty50"}, duty50, 1);
        end
        chk({tag, ":timeout"}, timeout, 0);
        @(negedge clk_in);
        chk({tag, ":pulse"}, done, 0);
        chk({tag, ":idle"}, busy, 0);
        chk({tag, ":ndone"}, ndone - nd0, 1);
    endtask

    initial begin
        int k, nd0, hh, hl;
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst:busy", busy, 0);
        chk("rst:done", done, 0);
        chk("rst:high", high_cnt, 0);
        chk("rst:low", low_cnt, 0);
        chk("rst:period", period, 0);
        chk("rst:duty50", duty50, 0);
        chk("rst:timeout", timeout, 0);
        rst = 1'b1;

        meas("div8", 8, 8, 1'b0);
        meas("div7", 7, 7, 1'b0);
        meas("h2l6", 4, 12, 1'b0);

        // Stuck-low div_clk: watchdog aborts 255 cycles after entering ARM
        gen_en = 1'b0;
        repeat (4) @(negedge clk_in);
        nd0 = ndone;
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        k = 0;
        while (!done && k < 400) begin
            @(negedge clk_in);
            k++;
        end
        chk("to:latency", k, TO);
        chk("to:timeout", timeout, 1);
        chk("to:high_kept", high_cnt, 2);
        chk("to:low_kept", low_cnt, 6);
        chk("to:period_kept", period, 8);
        @(negedge clk_in);
        chk("to:busy", busy, 0);
        chk("to:ndone", ndone - nd0, 1);

        meas("sat", 200, 40, 1'b0);
        meas("spam", 40, 30, 1'b1);

        // Reset mid-HIGH: immediate clear, no done pulse, then clean recovery
        pat(40, 40);
        nd0 = ndone;
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        k = 0;
        while (div_clk && k < 100) begin @(negedge clk_in); k++; end
        while (!div_clk && k < 100) begin @(negedge clk_in); k++; end
        repeat (4) @(negedge clk_in);
        chk("rmid:busy_before", busy, 1);
        rst = 1'b0;
        #1;
        chk("rmid:busy", busy, 0);
        chk("rmid:high", high_cnt, 0);
        chk("rmid:low", low_cnt, 0);
        chk("rmid:period", period, 0);
        chk("rmid:duty50", duty50, 0);
        repeat (2) @(negedge clk_in);
        rst = 1'b1;
        repeat (150) @(negedge clk_in);
        chk("rmid:no_done", ndone - nd0, 0);
        chk("rmid:idle", busy, 0);
        meas("after_rst", 6, 10, 1'b0);

        for (int i = 0; i < 20; i++) begin
            hh = 2 * $urandom_range(1, 90);
            hl = 2 * $urandom_range(1, 90);
            if (hh + hl < 8) hl = 8 - hh;
            meas($sformatf("rnd%0d_h%0d_l%0d", i, hh / 2, hl / 2), hh, hl, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clk_div_meter.md
CLK_DIV_METER -- requirements
Module: clk_div_meter

Interface
REQ-001 Parameter CNT_W, default 8, width of the phase counters and count outputs.
REQ-002 Parameter TIMEOUT, default 255, maximum clk_in cycles allowed between consecutive div_clk edges before the measurement is aborted.
REQ-003 clk_in  input  1  reference clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 div_clk  input  1  divided clock under test, asynchronous to clk_in, up to clk_in/4.
REQ-006 start  input  1  one-cycle request to begin a single measurement.
REQ-007 busy  output  1  high while a measurement is in progress.
REQ-008 done  output  1  one-cycle pulse when a measurement ends, whether complete or timed out.
REQ-009 high_cnt  output  CNT_W  clk_in samples of div_clk high during one period.
REQ-010 low_cnt  output  CNT_W  clk_in samples of div_clk low during one period.
REQ-011 period  output  CNT_W+1  high_cnt + low_cnt.
REQ-012 duty50  output  1  set when |high_cnt - low_cnt| <= 1.
REQ-013 timeout  output  1  set when the last measurement was aborted.

Function
REQ-014 div_clk SHALL pass through the input stage of REQ-030/031 to give s; prev holds s from the previous cycle; rise = s & ~prev; fall = ~s & prev.
REQ-015 FSM states: IDLE, ARM, HIGH, LOW, DONE; busy = 1 in ARM, HIGH and LOW.
REQ-016 IDLE: start=1 -> ARM; clear timeout; high_cnt, low_cnt, period and duty50 hold their old values until DONE.
REQ-017 ARM: rise -> HIGH, with hcnt = 1.
REQ-018 HIGH: each cycle with s=1, hcnt += 1; fall -> LOW, with lcnt = 1.
REQ-019 LOW: each cycle with s=0, lcnt += 1; rise -> DONE.
REQ-020 DONE: latch high_cnt = hcnt, low_cnt = lcnt, period = hcnt + lcnt at CNT_W+1 bits (no overflow), and duty50; assert done for exactly one cycle; go to IDLE on the next cycle.
REQ-021 hcnt and lcnt SHALL saturate at 2^CNT_W - 1 and SHALL NOT wrap.
REQ-022 Edge watchdog: reset on every rise or fall, incremented each cycle in ARM, HIGH or LOW; on reaching TIMEOUT -> timeout = 1, done pulse, counts unchanged, return to IDLE.
REQ-023 start SHALL be ignored while busy = 1 or in DONE.
REQ-024 If a watchdog expiry and an edge occur in the same cycle, the edge SHALL win and the watchdog SHALL restart.
REQ-025 A measurement SHALL always begin at the first rise after start, even if div_clk is already high when start arrives.

Reset
REQ-026 rst low SHALL force state IDLE immediately, whatever the current state.
REQ-027 rst low SHALL clear all outputs to 0: busy, done, high_cnt, low_cnt, period, duty50 and timeout.
REQ-028 rst low SHALL clear the internal counters, the watchdog, prev and the synchronizer flops to 0.
REQ-029 Reset during a measurement SHALL abort it with no done pulse.

Configuration
REQ-030 With macro DIV_METER_SYNC_EN defined, div_clk SHALL pass through a 2-flop synchronizer before s, adding 2 cycles of latency but leaving the counts unchanged.
REQ-031 Without DIV_METER_SYNC_EN, s SHALL be div_clk registered once; use this only when div_clk is generated from clk_in.

Verification
REQ-032 div_clk = clk_in/8, 50% duty, start pulse -> done after one full period; high_cnt=4, low_cnt=4, period=8, duty50=1, timeout=0.
REQ-033 div_clk = 50%-duty divide-by-7 built on both edges of clk_in -> period=7; {high_cnt,low_cnt} = {4,3} or {3,4}; duty50=1.
REQ-034 div_clk high 2 cycles, low 6 cycles -> high_cnt=2, low_cnt=6, period=8, duty50=0.
REQ-035 div_clk held at 0, start pulse, TIMEOUT=255 -> done and timeout=1 exactly 255 cycles after entering ARM; busy=0 afterwards.
REQ-036 start repeated while busy, then rst pulsed low mid-HIGH -> extra starts have no effect; rst aborts with no done pulse and all outputs 0; a following measurement is correct.
